muldiv_alu: RTL and testbench
=============================

MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, operand/result width; OPCODE_LENGTH, default 5, Operation width.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  Operation/SrcA/SrcB valid this cycle.
REQ-005 in_ready  output  1  block accepts a new operation this cycle.
REQ-006 SrcA, SrcB  input  DATA_WIDTH  operands, unsigned bit vectors unless the operation states otherwise.
REQ-007 Operation  input  OPCODE_LENGTH  opcode; bit 4 = 0 base ALU group, 1 mul/div group.
REQ-008 flush  input  1  abort the operation in flight; no result produced.
REQ-009 out_valid  output  1  one-cycle pulse, ALUResult valid.
REQ-010 ALUResult  output  DATA_WIDTH  registered result; holds last value until next out_valid.
REQ-011 busy  output  1  high while an iterative operation is in flight.

Function
REQ-012 Base group codes SHALL be: 00000 AND, 00001 OR, 00010 ADD, 00100 SLL, 00101 SRL, 00111 SRA, 01000 EQ (1/0), 01100 SLT signed (1/0); other base codes SHALL yield 0 with out_valid asserted.
REQ-013 Shift amount SHALL be SrcB[$clog2(DATA_WIDTH)-1:0]; upper SrcB bits ignored.
REQ-014 Mul/div codes SHALL be: 10000 MUL (low half), 10001 MULH (s×s high), 10010 MULHSU (s×u high), 10011 MULHU (u×u high), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; codes 11000-11111 SHALL behave as base-group undefined (result 0, latency 1).
REQ-015 Handshake: an operation SHALL be accepted in any cycle where in_valid && in_ready && !flush.
REQ-016 Base-group latency SHALL be 1: accepted at edge T, out_valid high in cycle T+1.
REQ-017 Mul/div latency SHALL be DATA_WIDTH+2: accepted at edge T, out_valid high in cycle T+DATA_WIDTH+2, independent of operand values.
REQ-018 FSM states SHALL be IDLE, BUSY, DONE; IDLE->BUSY on accepted mul/div; BUSY->DONE after DATA_WIDTH iteration cycles; DONE->IDLE after one cycle (or DONE->BUSY/IDLE on a same-cycle accept).
REQ-019 in_ready SHALL be 1 in IDLE and DONE, 0 in BUSY; busy SHALL be 1 exactly in BUSY.
REQ-020 Multiply SHALL be iterative shift-add over a 2×DATA_WIDTH product, with sign correction from operand signs per REQ-014.
REQ-021 Divide SHALL be iterative restoring on magnitudes, signs applied on the final cycle (quotient sign = sign A xor sign B, remainder sign = sign A).
REQ-022 Divide by zero SHALL give quotient all-ones (DIV/DIVU) and remainder = SrcA (REM/REMU).
REQ-023 Signed overflow (SrcA = most-negative, SrcB = -1) SHALL give DIV = most-negative, REM = 0.
REQ-024 flush in BUSY SHALL return to IDLE next cycle, no out_valid; flush in IDLE/DONE SHALL block acceptance that cycle only; a DONE-cycle out_valid SHALL still be emitted.
REQ-025 in_valid while in_ready = 0 SHALL be ignored (no queuing); the source holds it.

Reset
REQ-026 reset SHALL force state IDLE, out_valid 0, busy 0, ALUResult 0, in_ready 1 at the next edge, overriding in_valid and flush.
REQ-027 reset during BUSY SHALL discard the in-flight operation with no out_valid.

Structure
REQ-028 A shared package alu_pkg SHALL hold the opcode enum (all REQ-012/REQ-014 codes) and the FSM state enum.
REQ-029 The iterative mul/div datapath SHALL be a sub-module muldiv_iter (start, op, operands in; done, result out); muldiv_alu holds the handshake, FSM and base-group logic.

Verification
REQ-030 ADD 0x7FFFFFFF + 1 -> out_valid next cycle, ALUResult 0x80000000; SRA 0x80000000 by 31 -> 0xFFFFFFFF.
REQ-031 MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; out_valid exactly 34 cycles after accept.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
REQ-033 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF.
REQ-034 flush 10 cycles into MUL -> no out_valid, in_ready 1 next cycle; reset mid-DIVU -> all outputs at reset values.
REQ-035 Back-to-back: MUL then ADD presented in DONE cycle -> two out_valid pulses, ADD result one cycle after MUL result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the mul/div ALU.
// Opcode bit 4 selects the mul/div group; 11xxx decodes as base-group undefined.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_SLL    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_SRA    = 5'b00111,
    OP_EQ     = 5'b01000,
    OP_SLT    = 5'b01100,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // True for the opcodes served by the iterative datapath.
  function automatic logic is_iter(input logic [4:0] op);
    return op[4] & ~op[3];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// One step per cycle for DATA_WIDTH cycles; signs are applied on the output.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_END = CW'(W);

  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  a_q, a_d;
  logic [2:0]    op_q, op_d;
  logic          neg_q, neg_d;
  logic          nrem_q, nrem_d;
  logic          dz_q, dz_d;
  logic          act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          sa, sb;
  logic [W-1:0]  ma, mb;
  logic [W:0]    sum;
  logic [W:0]    r, t;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]  quot_s, rem_s;

  // Operand sign handling at start: which operands are signed per opcode.
  always_comb begin
    sa = a[W-1] & (op[2] ? ~op[0] : (op == 3'd1 || op == 3'd2));
    sb = b[W-1] & (op[2] ? ~op[0] : (op == 3'd1));
    ma = sa ? -a : a;
    mb = sb ? -b : b;
  end

  // One multiply step and one divide step from the current state.
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    r   = {hi_q, lo_q[W-1]};
    t   = r - {1'b0, b_q};
  end

  // Load on start, then iterate until the step count is reached.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    a_d    = a_q;
    op_d   = op_q;
    neg_d  = neg_q;
    nrem_d = nrem_q;
    dz_d   = dz_q;
    act_d  = act_q;
    cnt_d  = cnt_q;
    if (start) begin
      hi_d   = '0;
      lo_d   = ma;
      b_d    = mb;
      a_d    = a;
      op_d   = op;
      neg_d  = sa ^ sb;
      nrem_d = sa;
      dz_d   = (b == '0);
      act_d  = 1'b1;
      cnt_d  = '0;
    end else if (act_q && cnt_q != CNT_END) begin
      if (op_q[2]) begin
        hi_d = t[W] ? r[W-1:0] : t[W-1:0];
        lo_d = {lo_q[W-2:0], ~t[W]};
      end else begin
        hi_d = sum[W:1];
        lo_d = {sum[0], lo_q[W-1:1]};
      end
      cnt_d = cnt_q + 1'b1;
    end else if (done) begin
      act_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      a_q    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      nrem_q <= 1'b0;
      dz_q   <= 1'b0;
      act_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      a_q    <= a_d;
      op_q   <= op_d;
      neg_q  <= neg_d;
      nrem_q <= nrem_d;
      dz_q   <= dz_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done = act_q && (cnt_q == CNT_END);

  // Sign correction and result selection; divide-by-zero overrides.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quot_s = neg_q ? -lo_q : lo_q;
    rem_s  = nrem_q ? -hi_q : hi_q;
    case (op_q)
      3'd0:                result = prod_s[W-1:0];
      3'd1, 3'd2, 3'd3:    result = prod_s[2*W-1:W];
      3'd4, 3'd5:          result = dz_q ? '1 : quot_s;
      default:             result = dz_q ? a_q : rem_s;
    endcase
  end

endmodule

// File: rtl/muldiv_alu.sv
// ALU with single-cycle base ops and an iterative mul/div unit.
// Owns the valid/ready handshake, the IDLE/BUSY/DONE FSM and the result register.
module muldiv_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);

  localparam int SHW = $clog2(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ov_q, ov_d;

  logic [4:0]            op;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] base_res;
  logic                  accept;
  logic                  start;
  logic                  iter_done;
  logic [DATA_WIDTH-1:0] iter_res;

  assign op        = Operation[4:0];
  assign shamt     = SrcB[SHW-1:0];
  assign in_ready  = (state_q != ST_BUSY);
  assign busy      = (state_q == ST_BUSY);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = ov_q;
  assign ALUResult = res_q;

  muldiv_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op[2:0]),
    .a      (SrcA),
    .b      (SrcB),
    .done   (iter_done),
    .result (iter_res)
  );

  // Single-cycle base-group result; undefined codes give zero.
  always_comb begin
    base_res = '0;
    case (op)
      OP_AND: base_res = SrcA & SrcB;
      OP_OR:  base_res = SrcA | SrcB;
      OP_ADD: base_res = SrcA + SrcB;
      OP_SLL: base_res = SrcA << shamt;
      OP_SRL: base_res = SrcA >> shamt;
      OP_SRA: base_res = $signed(SrcA) >>> shamt;
      OP_EQ:  base_res = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      OP_SLT: base_res = {{(DATA_WIDTH-1){1'b0}},
                          $signed(SrcA) < $signed(SrcB)};
      default: base_res = '0;
    endcase
  end

  // Next-state, result capture and out_valid pulse.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ov_d    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (is_iter(op)) begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            res_d = base_res;
            ov_d  = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (iter_done) begin
          res_d   = iter_res;
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_muldiv_alu.sv
// Directed-vector bench for muldiv_alu.
// Table of ops with hand-computed results plus multi-cycle sequences.
module tb_muldiv_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA, SrcB;
  logic [4:0]  Operation;
  logic        flush;
  logic        out_valid;
  logic [31:0] ALUResult;
  logic        busy;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  muldiv_alu #(
    .DATA_WIDTH(32),
    .OPCODE_LENGTH(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .flush     (flush),
    .out_valid (out_valid),
    .ALUResult (ALUResult),
    .busy      (busy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one op when ready, return result and cycles to out_valid.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    Operation = op;
    SrcA = a;
    SrcB = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        res = ALUResult;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    int pulses;
    int seen;

    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    SrcA = '0;
    SrcB = '0;
    Operation = '0;

    vt.push_back('{5'b00000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
    vt.push_back('{5'b00001, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0});
    vt.push_back('{5'b00010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000});
    vt.push_back('{5'b00100, 32'h00000001, 32'h00000021, 32'h00000002});
    vt.push_back('{5'b00101, 32'h80000000, 32'h00000004, 32'h08000000});
    vt.push_back('{5'b00111, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF});
    vt.push_back('{5'b01000, 32'h00000005, 32'h00000005, 32'h00000001});
    vt.push_back('{5'b01000, 32'h00000005, 32'h00000006, 32'h00000000});
    vt.push_back('{5'b01100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    vt.push_back('{5'b01100, 32'h00000001, 32'hFFFFFFFF, 32'h00000000});
    vt.push_back('{5'b00011, 32'h12345678, 32'h11111111, 32'h00000000});
    vt.push_back('{5'b11000, 32'h12345678, 32'h11111111, 32'h00000000});
    vt.push_back('{5'b10000, 32'h00000007, 32'h00000006, 32'h0000002A});
    vt.push_back('{5'b10000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE});
    vt.push_back('{5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    vt.push_back('{5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vt.push_back('{5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    vt.push_back('{5'b10001, 32'h80000000, 32'h80000000, 32'h40000000});
    vt.push_back('{5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vt.push_back('{5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000});
    vt.push_back('{5'b10101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF});
    vt.push_back('{5'b10111, 32'h00000005, 32'h00000000, 32'h00000005});
    vt.push_back('{5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD});
    vt.push_back('{5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF});
    vt.push_back('{5'b10101, 32'h00000064, 32'h00000007, 32'h0000000E});
    vt.push_back('{5'b10111, 32'h00000064, 32'h00000007, 32'h00000002});
    vt.push_back('{5'b10100, 32'h00000007, 32'h00000000, 32'hFFFFFFFF});
    vt.push_back('{5'b10110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB});
    vt.push_back('{5'b10100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD});
    vt.push_back('{5'b10110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001});

    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst ALUResult", ALUResult, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // table
    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, res, lat);
      chk($sformatf("vec%0d op%b result", i, vt[i].op), res, vt[i].exp);
      chk($sformatf("vec%0d op%b latency", i, vt[i].op), 32'(lat),
          (vt[i].op[4] && !vt[i].op[3]) ? 32'd34 : 32'd1);
      @(negedge clk);
    end

    // flush in IDLE blocks acceptance for that cycle only
    Operation = 5'b00010;
    SrcA = 32'd10;
    SrcB = 32'd20;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle flush no out_valid", {31'b0, out_valid}, 32'd0);
    run_op(5'b00010, 32'd10, 32'd20, res, lat);
    chk("after idle flush ADD", res, 32'd30);
    @(negedge clk);

    // in_valid during BUSY is ignored
    Operation = 5'b10000;
    SrcA = 32'd9;
    SrcB = 32'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("busy flag", {31'b0, busy}, 32'd1);
    chk("busy in_ready", {31'b0, in_ready}, 32'd0);
    Operation = 5'b00010;
    SrcA = 32'd1;
    SrcB = 32'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    res = '0;
    pulses = 0;
    for (int n = 2; n <= 60; n++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          res = ALUResult;
        end
      end
    end
    chk("busy ignore latency", 32'(lat), 32'd34);
    chk("busy ignore result", res, 32'd81);
    chk("busy ignore pulses", 32'(pulses), 32'd1);

    // flush 10 cycles into MUL
    Operation = 5'b10000;
    SrcA = 32'd3;
    SrcB = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 0; n < 10; n++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush busy", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("flush no out_valid", 32'(seen), 32'd0);
    chk("flush result held", ALUResult, 32'd81);

    // back-to-back: ADD in MUL's DONE cycle
    run_op(5'b10000, 32'd3, 32'd4, res, lat);
    chk("b2b MUL result", res, 32'd12);
    chk("b2b MUL latency", 32'(lat), 32'd34);
    chk("b2b DONE in_ready", {31'b0, in_ready}, 32'd1);
    Operation = 5'b00010;
    SrcA = 32'd2;
    SrcB = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b ADD out_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b ADD result", ALUResult, 32'd5);

    // reset mid-DIVU
    @(negedge clk);
    Operation = 5'b10101;
    SrcA = 32'd100;
    SrcB = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 0; n < 5; n++) @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst ALUResult", ALUResult, 32'd0);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("midrst no out_valid", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
